booth_mac_ctrl: RTL and testbench
=================================

Name: booth_mac_ctrl

Overview:
- Dot-product controller wrapped around the Booth multiplier; sits directly upstream and downstream of it.
- Accepts a stream of signed 8-bit operand pairs and issues each pair to the multiplier with a one-cycle St pulse.
- Waits for the multiplier's Ready, sign-extends the 15-bit Product and accumulates it.
- Presents the final sum when the pair flagged last has been accumulated.

Parameters:
- MP_W, 8: multiplier and multiplicand width.
- PD_W, 15: multiplier Product width (MP_W+MP_W-1).
- ACC_W, 24: accumulator width; must be at least PD_W.
- TIMEOUT, 64: maximum cycles to wait for Ready after St.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept a pair.
- in_mtp  in  MP_W  multiplier, two's complement.
- in_mtc  in  MP_W  multiplicand, two's complement.
- in_last  in  1  this pair ends the current dot product.
- mult_st  out  1  start pulse to multiplier (St).
- mult_mtp  out  MP_W  registered multiplier operand (Mtp).
- mult_mtc  out  MP_W  registered multiplicand operand (Mtc).
- mult_ready  in  1  multiplier Ready.
- mult_product  in  PD_W  multiplier Product, signed.
- acc_valid  out  1  result valid.
- acc_ready  in  1  downstream accepts result.
- acc_out  out  ACC_W  accumulated sum, signed.
- acc_ovf  out  1  signed overflow occurred during this sum (sticky per sum).
- acc_err  out  1  at least one multiply timed out during this sum.

Behaviour:
- Reset (rst_n low at clk edge) values:
  - All outputs 0 except in_ready, which is 1 once in IDLE.
  - Accumulator, ovf and err flags cleared; state IDLE.
  - Reset mid-operation abandons the sum. A later Ready edge must not be accumulated.
- FSM states: IDLE, ISSUE, WAIT, ACCUM, OUT.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready: latch in_mtp/in_mtc into mult_mtp/mult_mtc, latch in_last, go to ISSUE.
- ISSUE:
  - mult_st=1 for exactly this one cycle; in_ready=0.
  - Clear timeout counter; go to WAIT.
  - mult_mtp/mult_mtc stay stable from ISSUE through ACCUM.
- WAIT:
  - Rising-edge detect on mult_ready: registered previous value, edge = mult_ready && !prev.
  - prev is forced to 1 in ISSUE, so a Ready held high from the previous op never counts as completion.
  - On edge: capture mult_product into a holding register and go to ACCUM.
  - Counter increments each WAIT cycle. If it reaches TIMEOUT with no edge: set err flag, treat product as 0, go to ACCUM.
- ACCUM:
  - acc <= acc + sign_extend(product, ACC_W).
  - Signed overflow: both operands have the same sign and the result sign differs. On overflow set the ovf flag; the sum wraps (no saturation).
  - If latched last=1: go to OUT. Otherwise go to IDLE.
- OUT:
  - acc_valid=1; acc_out/acc_ovf/acc_err hold stable until acc_valid&&acc_ready.
  - On handshake: clear accumulator and flags, deassert acc_valid next cycle, go to IDLE.
  - in_ready=0 throughout OUT, so a new sum cannot start until the result is taken.
- Latency:
  - Pair accept to St: 1 cycle.
  - Ready edge to accumulator update: 2 cycles.
  - Last accumulation to acc_valid: 1 cycle.
- Throughput: one pair per multiply plus 3 cycles of overhead.
- Single-pair sum (in_last on first pair): result equals sign-extended product.
- acc_ready held high before acc_valid: the handshake completes in the first OUT cycle.
- mult_ready toggling outside WAIT is ignored.

Test Plan:
- Multiplier model: Ready drops on St and rises 9 cycles later with the correct product. Stream pairs (102,51), (-90,102), (107,-114), (-52,-103), (-9,-13 last) -> one acc_valid with acc_out = -10703, ovf=0, err=0, exactly five St pulses.
- Single pair (-9,-13 last) -> acc_out = 117. Then hold acc_ready=0 for 10 cycles -> acc_out stable, in_ready=0. Raise acc_ready -> result accepted, next sum starts from 0.
- ACC_W=16, four pairs (100,100), last on the fourth -> acc_out = -25536 (0x9C40), acc_ovf=1.
- Model never raises Ready on the second of three pairs (102,51), (1,1), (2,3 last) -> timeout after 64 WAIT cycles, acc_out = 5208, acc_err=1.
- Ready held continuously high by the model before St -> no accumulation until a genuine low-to-high edge. Assert rst_n=0 in WAIT -> outputs cleared next cycle; a late Ready edge does not change acc_out on the following sum.

Source files
------------

// File: rtl/booth_mac_ctrl.sv
// booth_mac_ctrl: dot-product controller wrapped around a sequential Booth multiplier.
// Issues operand pairs with a St pulse, waits for a Ready rising edge and accumulates signed products.
module booth_mac_ctrl #(
  parameter int MP_W    = 8,
  parameter int PD_W    = 15,
  parameter int ACC_W   = 24,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MP_W-1:0]  in_mtp,
  input  logic [MP_W-1:0]  in_mtc,
  input  logic             in_last,
  output logic             mult_st,
  output logic [MP_W-1:0]  mult_mtp,
  output logic [MP_W-1:0]  mult_mtc,
  input  logic             mult_ready,
  input  logic [PD_W-1:0]  mult_product,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_ovf,
  output logic             acc_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACCUM, OUT} state_t;

  state_t           state;
  logic             last;
  logic             ready_prev;
  logic [CNT_W-1:0] wait_cnt;
  logic [PD_W-1:0]  product;
  logic             ready_edge;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_sum;
  logic             sum_ovf;

  assign ready_edge = mult_ready && !ready_prev;
  assign prod_ext   = ACC_W'($signed(product));
  assign acc_sum    = acc_out + prod_ext;
  // Two's-complement overflow: like-signed operands producing a result of the other sign.
  assign sum_ovf    = (acc_out[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (acc_sum[ACC_W-1] != acc_out[ACC_W-1]);

  // NOTE: every register lives in this one clocked block and uses non-blocking
  // assignments, so all next-state values are computed from pre-edge state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      mult_st    <= 1'b0;
      mult_mtp   <= '0;
      mult_mtc   <= '0;
      last       <= 1'b0;
      ready_prev <= 1'b1;
      wait_cnt   <= '0;
      product    <= '0;
      acc_valid  <= 1'b0;
      acc_out    <= '0;
      acc_ovf    <= 1'b0;
      acc_err    <= 1'b0;
    end else begin
      mult_st <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mult_mtp <= in_mtp;
            mult_mtc <= in_mtc;
            last     <= in_last;
            in_ready <= 1'b0;
            mult_st  <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          // A Ready still high from the previous multiply must not look like an edge.
          ready_prev <= 1'b1;
          wait_cnt   <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          ready_prev <= mult_ready;
          wait_cnt   <= wait_cnt + CNT_W'(1);
          if (ready_edge) begin
            product <= mult_product;
            state   <= ACCUM;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            product <= '0;
            acc_err <= 1'b1;
            state   <= ACCUM;
          end
        end
        ACCUM: begin
          acc_out <= acc_sum;
          if (sum_ovf) acc_ovf <= 1'b1;
          if (last) begin
            acc_valid <= 1'b1;
            state     <= OUT;
          end else begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        OUT: begin
          if (acc_ready) begin
            acc_valid <= 1'b0;
            acc_out   <= '0;
            acc_ovf   <= 1'b0;
            acc_err   <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mac_ctrl.sv
// tb_booth_mac_ctrl: directed and random dot products against a behavioural multiplier and sum model.
// A second instance with a 16-bit accumulator runs in lockstep to exercise wrap-around and overflow.
module tb_booth_mac_ctrl;

  localparam int MP_W    = 8;
  localparam int PD_W    = 15;
  localparam int ACC_W   = 24;
  localparam int TIMEOUT = 64;

  typedef enum int {M_NORM, M_HANG, M_HOLD} mode_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              acc_ready = 1'b0;
  logic [MP_W-1:0]   in_mtp = '0;
  logic [MP_W-1:0]   in_mtc = '0;
  logic              mult_ready;
  logic [PD_W-1:0]   mult_product;

  logic              in_ready, mult_st, acc_valid, acc_ovf, acc_err;
  logic [MP_W-1:0]   mult_mtp, mult_mtc;
  logic [ACC_W-1:0]  acc_out;
  logic              in_ready16, mult_st16, acc_valid16, acc_ovf16, acc_err16;
  logic [MP_W-1:0]   mult_mtp16, mult_mtc16;
  logic [15:0]       acc_out16;

  int          checks = 0;
  int          errors = 0;
  bit          mdl_on = 1'b0;
  mode_t       mode = M_NORM;
  int          mdl_cnt, hold_cnt, cyc;
  logic [15:0] st_ops[$];
  logic [15:0] st_ops16[$];
  logic [15:0] sent_ops[$];
  int          st_cyc[$];
  longint      exp_prod[$];
  bit          exp_err = 1'b0;

  booth_mac_ctrl #(.MP_W(MP_W), .PD_W(PD_W), .ACC_W(ACC_W), .TIMEOUT(TIMEOUT)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mtp(in_mtp), .in_mtc(in_mtc), .in_last(in_last), .mult_st(mult_st),
    .mult_mtp(mult_mtp), .mult_mtc(mult_mtc), .mult_ready(mult_ready),
    .mult_product(mult_product), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_out(acc_out), .acc_ovf(acc_ovf), .acc_err(acc_err)
  );

  booth_mac_ctrl #(.MP_W(MP_W), .PD_W(PD_W), .ACC_W(16), .TIMEOUT(TIMEOUT)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .in_mtp(in_mtp), .in_mtc(in_mtc), .in_last(in_last), .mult_st(mult_st16),
    .mult_mtp(mult_mtp16), .mult_mtc(mult_mtc16), .mult_ready(mult_ready),
    .mult_product(mult_product), .acc_valid(acc_valid16), .acc_ready(acc_ready),
    .acc_out(acc_out16), .acc_ovf(acc_ovf16), .acc_err(acc_err16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: Ready drops on St and rises ~9 cycles later, or never (hang),
  // or stays high for 20 cycles before a genuine low-to-high edge (hold).
  always @(posedge clk) begin
    if (!mdl_on) begin
      mult_ready   <= 1'b1;
      mult_product <= '0;
      mdl_cnt      <= 0;
      hold_cnt     <= 0;
    end else if (mult_st) begin
      mult_product <= PD_W'(int'($signed(mult_mtp)) * int'($signed(mult_mtc)));
      if (mode == M_HOLD) begin
        hold_cnt <= 20;
        mdl_cnt  <= 0;
      end else begin
        mult_ready <= 1'b0;
        hold_cnt   <= 0;
        mdl_cnt    <= (mode == M_HANG) ? 0 : 9;
      end
    end else begin
      if (hold_cnt == 1) begin
        mult_ready <= 1'b0;
        mdl_cnt    <= 3;
      end
      if (hold_cnt > 0) hold_cnt <= hold_cnt - 1;
      if (mdl_cnt == 1) mult_ready <= 1'b1;
      if (mdl_cnt > 0) mdl_cnt <= mdl_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (mult_st) begin
      st_ops.push_back({mult_mtp, mult_mtc});
      st_cyc.push_back(cyc);
    end
    if (mult_st16) st_ops16.push_back({mult_mtp16, mult_mtc16});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint wrap_w(input longint v, input int w);
    longint m, h, r;
    m = longint'(1) << w;
    h = m / 2;
    r = (v + h) % m;
    if (r < 0) r += m;
    return r - h;
  endfunction

  // Reference sum: plain integer accumulation, wrapped to w bits, sticky range overflow.
  function automatic void model_sum(input int w, output longint s, output bit ovf);
    longint h, t;
    h = longint'(1) << (w - 1);
    s = 0;
    ovf = 1'b0;
    foreach (exp_prod[i]) begin
      t = s + exp_prod[i];
      if (t >= h || t < -h) ovf = 1'b1;
      s = wrap_w(t, w);
    end
  endfunction

  task automatic clear_model();
    sent_ops.delete();
    st_ops.delete();
    st_ops16.delete();
    st_cyc.delete();
    exp_prod.delete();
    exp_err = 1'b0;
  endtask

  task automatic send_pair(input int a, input int b, input bit last, input mode_t m);
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("in_ready_wait", 32'(in_ready), 32'd1);
    mode     = m;
    in_valid = 1'b1;
    in_mtp   = 8'(a);
    in_mtc   = 8'(b);
    in_last  = last;
    sent_ops.push_back({8'(a), 8'(b)});
    exp_prod.push_back((m == M_HANG) ? 64'sd0 : longint'(a * b));
    if (m == M_HANG) exp_err = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collect(input string tag, input bit pre_ready, input int hold);
    longint           s24, s16;
    bit               o24, o16;
    logic [ACC_W-1:0] e24;
    logic [15:0]      e16;
    int               n;
    model_sum(ACC_W, s24, o24);
    model_sum(16, s16, o16);
    e24 = ACC_W'(s24);
    e16 = 16'(s16);
    n = 0;
    acc_ready = pre_ready;
    while (acc_valid !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"},   32'(acc_valid),   32'd1);
    check({tag, "_valid16"}, 32'(acc_valid16), 32'd1);
    check({tag, "_acc"},     32'(acc_out),     32'(e24));
    check({tag, "_ovf"},     32'(acc_ovf),     32'(o24));
    check({tag, "_err"},     32'(acc_err),     32'(exp_err));
    check({tag, "_acc16"},   32'(acc_out16),   32'(e16));
    check({tag, "_ovf16"},   32'(acc_ovf16),   32'(o16));
    check({tag, "_err16"},   32'(acc_err16),   32'(exp_err));
    check({tag, "_st_cnt"},  32'(st_ops.size()),   32'(sent_ops.size()));
    check({tag, "_st_cnt16"}, 32'(st_ops16.size()), 32'(sent_ops.size()));
    for (int i = 0; i < sent_ops.size() && i < st_ops.size(); i++)
      check({tag, "_ops"}, 32'(st_ops[i]), 32'(sent_ops[i]));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_acc"},   32'(acc_out),   32'(e24));
      check({tag, "_hold_valid"}, 32'(acc_valid), 32'd1);
      check({tag, "_hold_rdy"},   32'(in_ready),  32'd0);
    end
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    check({tag, "_drop"},   32'(acc_valid),  32'd0);
    check({tag, "_clr"},    32'(acc_out),    32'd0);
    check({tag, "_rdy"},    32'(in_ready),   32'd1);
    check({tag, "_rdy16"},  32'(in_ready16), 32'd1);
    clear_model();
  endtask

  initial begin
    int gap;
    bit gap_ok;
    int len;
    bit pr;
    int a, b;

    repeat (3) @(negedge clk);
    check("rst_in_ready",   32'(in_ready),   32'd1);
    check("rst_in_ready16", 32'(in_ready16), 32'd1);
    check("rst_st",         32'(mult_st),    32'd0);
    check("rst_valid",      32'(acc_valid),  32'd0);
    check("rst_acc",        32'(acc_out),    32'd0);
    check("rst_ovf",        32'(acc_ovf),    32'd0);
    check("rst_err",        32'(acc_err),    32'd0);
    check("rst_mtp",        32'(mult_mtp),   32'd0);
    check("rst_mtc",        32'(mult_mtc),   32'd0);
    rst_n  = 1'b1;
    mdl_on = 1'b1;
    clear_model();

    // Five-pair stream: -10703, five St pulses.
    send_pair(102, 51, 1'b0, M_NORM);
    send_pair(-90, 102, 1'b0, M_NORM);
    send_pair(107, -114, 1'b0, M_NORM);
    send_pair(-52, -103, 1'b0, M_NORM);
    send_pair(-9, -13, 1'b1, M_NORM);
    collect("stream", 1'b0, 0);

    // Single pair, result held off for 10 cycles.
    send_pair(-9, -13, 1'b1, M_NORM);
    collect("single", 1'b0, 10);

    // 4 x 10000: wraps to 0x9C40 with overflow in the 16-bit instance.
    for (int i = 0; i < 4; i++) send_pair(100, 100, (i == 3), M_NORM);
    collect("ovf", 1'b1, 0);

    // Second multiply never completes: timeout contributes 0 and flags err.
    send_pair(102, 51, 1'b0, M_NORM);
    send_pair(1, 1, 1'b0, M_HANG);
    send_pair(2, 3, 1'b1, M_NORM);
    @(negedge clk);
    gap_ok = 1'b0;
    if (st_cyc.size() == 3) begin
      gap    = st_cyc[2] - st_cyc[1];
      gap_ok = (gap >= TIMEOUT + 2) && (gap <= TIMEOUT + 4);
    end
    check("timeout_gap", 32'(gap_ok), 32'd1);
    collect("tmo", 1'b0, 0);

    // Ready held high across St: nothing may accumulate before a real edge.
    send_pair(-9, -13, 1'b1, M_HOLD);
    repeat (12) @(negedge clk);
    check("hold_no_valid", 32'(acc_valid), 32'd0);
    check("hold_no_acc",   32'(acc_out),   32'd0);
    collect("hold", 1'b1, 0);

    // Reset while waiting; the late Ready edge must be ignored.
    send_pair(5, 7, 1'b0, M_NORM);
    send_pair(6, 6, 1'b0, M_NORM);
    check("pre_rst_acc", 32'(acc_out), 32'd35);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready),  32'd1);
    check("mid_rst_st",       32'(mult_st),   32'd0);
    check("mid_rst_valid",    32'(acc_valid), 32'd0);
    check("mid_rst_acc",      32'(acc_out),   32'd0);
    check("mid_rst_mtp",      32'(mult_mtp),  32'd0);
    rst_n = 1'b1;
    clear_model();
    repeat (15) @(negedge clk);
    check("late_edge_acc",   32'(acc_out),   32'd0);
    check("late_edge_valid", 32'(acc_valid), 32'd0);
    send_pair(3, 4, 1'b1, M_NORM);
    collect("post_rst", 1'b0, 0);

    // Random sums.
    for (int s = 0; s < 6; s++) begin
      len = int'($urandom_range(1, 4));
      pr  = 1'($urandom_range(0, 1));
      for (int k = 0; k < len; k++) begin
        a = int'($urandom_range(0, 254)) - 127;
        b = int'($urandom_range(0, 254)) - 127;
        send_pair(a, b, (k == len - 1), M_NORM);
      end
      collect("rand", pr, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
